mcu_spi_slave: RTL and testbench

//  SPI mode-0 slave front end between the MCU SPI pins and the command interpreter.

---
 rtl/mcu_spi_slave.sv | 260 ++++++++++++++++++++++++++
 tb/tb_mcu_spi_slave.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : mcu_spi_slave
// Purpose  : SPI mode-0 slave front end between the MCU SPI pins and the
//            command interpreter. SCK/MOSI/SSEL are oversampled in the clk
//            domain. MOSI is deserialised into bytes: the first byte of a
//            frame is the command, every later byte is a parameter.
//            spi_data_out is serialised onto MISO, MSB first, one byte
//            behind the interpreter.
// Options  : define MCU_SPI_TIMEOUT_EN to abort a frame after TIMEOUT_CYCLES
//            clk cycles without any SCK edge.
// Ports    :
//   clk           in   1   system clock, posedge
//   rst           in   1   synchronous active-high reset
//   SCK           in   1   SPI clock from MCU (asynchronous)
//   MOSI          in   1   SPI data from MCU (asynchronous)
//   SSEL          in   1   SPI select, active low (asynchronous)
//   MISO          out  1   SPI data to MCU
//   MISO_OE       out  1   1 = drive MISO pad, 0 = tristate
//   spi_data_out  in   8   byte returned to the MCU in the next byte slot
//   cmd_ready     out  1   1-cycle pulse, command byte complete
//   param_ready   out  1   1-cycle pulse, parameter byte complete
//   cmd_data      out  8   last command byte, held until the next command
//   param_data    out  8   last parameter byte, held until the next one
//   spi_byte_cnt  out  32  bytes completed in the current frame
//   spi_bit_cnt   out  3   bits received in the current byte
// Revision : 1.0  initial release
// ============================================================================
module mcu_spi_slave #(
  parameter int unsigned SYNC_STAGES    = 3,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SCK,
  input  logic        MOSI,
  input  logic        SSEL,
  output logic        MISO,
  output logic        MISO_OE,
  input  logic [7:0]  spi_data_out,
  output logic        cmd_ready,
  output logic        param_ready,
  output logic [7:0]  cmd_data,
  output logic [7:0]  param_data,
  output logic [31:0] spi_byte_cnt,
  output logic [2:0]  spi_bit_cnt
);

  localparam logic [31:0] C_BYTE_CNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  state_e state_q, state_d;

  // --------------------------------------------------------------------------
  // Input synchronisers. Stage 0 samples the pin; edges are taken from the
  // last two stages (older = [SYNC_STAGES-1], newer = [SYNC_STAGES-2]).
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sck_sync_q,  sck_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] ssel_sync_q, ssel_sync_d;
  // Marks the synchronisers as refilled with real pin samples after reset,
  // so the idle reset value of SSEL is never mistaken for a real high level.
  logic [SYNC_STAGES-1:0] flush_q,     flush_d;

  logic sck_rise;
  logic sck_fall;
  logic mosi_s;
  logic ssel_s;
  logic flushed;

  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0],  SCK};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    ssel_sync_d = {ssel_sync_q[SYNC_STAGES-2:0], SSEL};
    flush_d     = {flush_q[SYNC_STAGES-2:0],     1'b1};
  end

  assign sck_rise = ~sck_sync_q[SYNC_STAGES-1] &  sck_sync_q[SYNC_STAGES-2];
  assign sck_fall =  sck_sync_q[SYNC_STAGES-1] & ~sck_sync_q[SYNC_STAGES-2];
  // MOSI is taken from the oldest stage: it is the sample just before the
  // SCK rise, well inside the MCU's setup window in mode 0.
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign ssel_s   = ssel_sync_q[SYNC_STAGES-1];
  assign flushed  = flush_q[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Frame state
  // --------------------------------------------------------------------------
  // armed: SSEL has been seen high since reset or since a timeout abort.
  // A frame may only start from an armed IDLE, so a frame interrupted by rst
  // or by a timeout is never resumed until SSEL toggles high then low.
  logic        armed_q,       armed_d;
  logic [2:0]  bit_cnt_q,     bit_cnt_d;
  logic [31:0] byte_cnt_q,    byte_cnt_d;
  logic [7:0]  rx_q,          rx_d;
  logic [7:0]  tx_q,          tx_d;
  logic [7:0]  cmd_data_q,    cmd_data_d;
  logic [7:0]  param_data_q,  param_data_d;
  logic        cmd_ready_q,   cmd_ready_d;
  logic        param_ready_q, param_ready_d;

  logic [7:0]  rx_byte;
  logic [31:0] byte_cnt_inc;
  logic        timeout_abort;

`ifdef MCU_SPI_TIMEOUT_EN
  // Idle counter: cleared by any SCK edge, counts only while a frame is open.
  logic [15:0] idle_cnt_q, idle_cnt_d;

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if ((state_q != ST_ACTIVE) || sck_rise || sck_fall) begin
      idle_cnt_d = 16'd0;
    end else if (idle_cnt_q != 16'hFFFF) begin
      idle_cnt_d = idle_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_q <= 16'd0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign timeout_abort = (state_q == ST_ACTIVE) && (idle_cnt_q >= TIMEOUT_CYCLES);
`else
  // No inactivity timeout in this build; TIMEOUT_CYCLES has no effect.
  assign timeout_abort = 1'b0 & (TIMEOUT_CYCLES != 16'd0);
`endif

  always_comb begin
    state_d       = state_q;
    armed_d       = armed_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    rx_d          = rx_q;
    tx_d          = tx_q;
    cmd_data_d    = cmd_data_q;
    param_data_d  = param_data_q;
    cmd_ready_d   = 1'b0;
    param_ready_d = 1'b0;

    rx_byte      = {rx_q[6:0], mosi_s};
    byte_cnt_inc = (byte_cnt_q == C_BYTE_CNT_MAX) ? byte_cnt_q : byte_cnt_q + 32'd1;

    if (flushed && ssel_s) begin
      armed_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        bit_cnt_d  = 3'd0;
        byte_cnt_d = 32'd0;
        if (!ssel_s && armed_q) begin
          // New frame: byte 0 always returns 8'h00.
          state_d = ST_ACTIVE;
          tx_d    = 8'h00;
          rx_d    = 8'h00;
        end
      end

      ST_ACTIVE: begin
        if (ssel_s) begin
          // SSEL high wins over a coincident SCK edge; partial byte dropped.
          state_d    = ST_IDLE;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = 32'd0;
        end else if (timeout_abort) begin
          state_d    = ST_IDLE;
          armed_d    = 1'b0;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = 32'd0;
        end else begin
          if (sck_rise) begin
            rx_d      = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              // Count, data and pulse all become visible in the same cycle.
              byte_cnt_d = byte_cnt_inc;
              if (byte_cnt_inc == 32'd1) begin
                cmd_data_d  = rx_byte;
                cmd_ready_d = 1'b1;
              end else begin
                param_data_d  = rx_byte;
                param_ready_d = 1'b1;
              end
            end
          end
          if (sck_fall) begin
            // First fall of a new byte slot (after byte 0) picks up the
            // interpreter's reply; every other fall advances the shifter.
            if ((bit_cnt_q == 3'd0) && (byte_cnt_q != 32'd0)) begin
              tx_d = spi_data_out;
            end else begin
              tx_d = {tx_q[6:0], 1'b0};
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q    <= '0;
      mosi_sync_q   <= '0;
      ssel_sync_q   <= '1;
      flush_q       <= '0;
      state_q       <= ST_IDLE;
      armed_q       <= 1'b0;
      bit_cnt_q     <= 3'd0;
      byte_cnt_q    <= 32'd0;
      rx_q          <= 8'h00;
      tx_q          <= 8'h00;
      cmd_data_q    <= 8'h00;
      param_data_q  <= 8'h00;
      cmd_ready_q   <= 1'b0;
      param_ready_q <= 1'b0;
    end else begin
      sck_sync_q    <= sck_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      ssel_sync_q   <= ssel_sync_d;
      flush_q       <= flush_d;
      state_q       <= state_d;
      armed_q       <= armed_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      rx_q          <= rx_d;
      tx_q          <= tx_d;
      cmd_data_q    <= cmd_data_d;
      param_data_q  <= param_data_d;
      cmd_ready_q   <= cmd_ready_d;
      param_ready_q <= param_ready_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign MISO_OE      = (state_q == ST_ACTIVE);
  assign MISO         = MISO_OE & tx_q[7];
  assign cmd_ready    = cmd_ready_q;
  assign param_ready  = param_ready_q;
  assign cmd_data     = cmd_data_q;
  assign param_data   = param_data_q;
  assign spi_byte_cnt = byte_cnt_q;
  assign spi_bit_cnt  = bit_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mcu_spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcu_spi_slave
// Purpose  : Self-checking bench for mcu_spi_slave. A byte table drives the
//            main frame; hand-written sequences cover abort, reset, stall
//            and a long random stream.
// Revision : 1.0  initial release
// ============================================================================
module tb_mcu_spi_slave;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        SCK  = 1'b0;
  logic        MOSI = 1'b0;
  logic        SSEL = 1'b1;
  logic        MISO;
  logic        MISO_OE;
  logic [7:0]  spi_data_out;
  logic        cmd_ready;
  logic        param_ready;
  logic [7:0]  cmd_data;
  logic [7:0]  param_data;
  logic [31:0] spi_byte_cnt;
  logic [2:0]  spi_bit_cnt;

  mcu_spi_slave #(
    .SYNC_STAGES    (3),
    .TIMEOUT_CYCLES (16'd100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .SCK          (SCK),
    .MOSI         (MOSI),
    .SSEL         (SSEL),
    .MISO         (MISO),
    .MISO_OE      (MISO_OE),
    .spi_data_out (spi_data_out),
    .cmd_ready    (cmd_ready),
    .param_ready  (param_ready),
    .cmd_data     (cmd_data),
    .param_data   (param_data),
    .spi_byte_cnt (spi_byte_cnt),
    .spi_bit_cnt  (spi_bit_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Pulse monitor: records every completed byte as reported by the DUT.
  int          ev_total  = 0;
  int          last_kind = 0;   // 1 = command, 2 = parameter, 3 = both
  logic [7:0]  last_data = 8'h00;
  logic [31:0] last_cnt  = 32'd0;

  always @(negedge clk) begin
    if (cmd_ready || param_ready) begin
      ev_total  <= ev_total + 1;
      last_kind <= (cmd_ready && param_ready) ? 3 : (cmd_ready ? 1 : 2);
      last_data <= cmd_ready ? cmd_data : param_data;
      last_cnt  <= spi_byte_cnt;
    end
  end

  // Interpreter reply: changes right after each pulse.
  logic [7:0] resp [8] = '{8'h77, 8'hA5, 8'h3C, 8'h5A, 8'h11, 8'h22, 8'h33, 8'h44};
  logic [31:0] ev_vec;
  assign ev_vec       = ev_total;
  assign spi_data_out = resp[ev_vec[2:0]];

  typedef struct {
    logic [7:0]  mosi;
    int          kind;
    logic [31:0] cnt;
    logic [7:0]  miso;
  } vec_t;

  vec_t vt [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Sends the top nbits of b MSB first; MOSI changes while SCK is low and
  // MISO is sampled just before each rising edge, as the MCU would.
  task automatic send_bits(input logic [7:0] b, input int nbits, input int half,
                           output logic [7:0] miso_b);
    miso_b = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      MOSI = b[7-i];
      repeat (half) @(negedge clk);
      miso_b = {miso_b[6:0], MISO};
      SCK = 1'b1;
      repeat (half) @(negedge clk);
      SCK = 1'b0;
    end
  endtask

  task automatic ssel_low();
    SSEL = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic ssel_high();
    SSEL = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_miso"},      {31'd0, MISO},        32'd0);
    check({tag, "_miso_oe"},   {31'd0, MISO_OE},     32'd0);
    check({tag, "_cmd_rdy"},   {31'd0, cmd_ready},   32'd0);
    check({tag, "_param_rdy"}, {31'd0, param_ready}, 32'd0);
    check({tag, "_cmd_data"},  {24'd0, cmd_data},    32'h00);
    check({tag, "_param_data"},{24'd0, param_data},  32'h00);
    check({tag, "_byte_cnt"},  spi_byte_cnt,         32'd0);
    check({tag, "_bit_cnt"},   {29'd0, spi_bit_cnt}, 32'd0);
  endtask

  initial begin
    logic [7:0]  m;
    logic [7:0]  b;
    logic [31:0] act;
    int          ev0;

    vt[0] = '{8'h10, 1, 32'd1, 8'h00};
    vt[1] = '{8'hAB, 2, 32'd2, 8'hA5};
    vt[2] = '{8'hCD, 2, 32'd3, 8'h3C};
    vt[3] = '{8'hEF, 2, 32'd4, 8'h5A};

    // ---------------- reset ----------------
    repeat (3) @(negedge clk);
    check_reset_values("rst0");
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // ---------------- frame: command + 3 parameters, MISO replies ----------
    ssel_low();
    check("t1_miso_oe", {31'd0, MISO_OE}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      ev0 = ev_total;
      send_bits(vt[i].mosi, 8, 8, m);
      repeat (2) @(negedge clk);
      check("t1_ev_count", 32'(ev_total - ev0), 32'd1);
      check("t1_kind",     32'(last_kind),      32'(vt[i].kind));
      check("t1_data",     {24'd0, last_data},  {24'd0, vt[i].mosi});
      check("t1_cnt",      last_cnt,            vt[i].cnt);
      check("t1_miso_byte",{24'd0, m},          {24'd0, vt[i].miso});
    end
    ssel_high();
    check("t1_end_byte_cnt", spi_byte_cnt, 32'd0);
    check("t1_end_miso_oe",  {31'd0, MISO_OE}, 32'd0);
    check("t1_hold_cmd",     {24'd0, cmd_data},   32'h10);
    check("t1_hold_param",   {24'd0, param_data}, 32'hEF);

    // ---------------- partial byte aborted by SSEL high ----------------
    ssel_low();
    ev0 = ev_total;
    send_bits(8'hC3, 5, 8, m);
    repeat (2) @(negedge clk);
    check("t3_bit_cnt_mid", {29'd0, spi_bit_cnt}, 32'd5);
    ssel_high();
    check("t3_no_pulse",    32'(ev_total - ev0),  32'd0);
    check("t3_bit_cnt",     {29'd0, spi_bit_cnt}, 32'd0);
    check("t3_byte_cnt",    spi_byte_cnt,         32'd0);
    check("t3_cmd_held",    {24'd0, cmd_data},    32'h10);

    // ---------------- rst in the middle of a parameter byte ----------------
    ssel_low();
    send_bits(8'h31, 8, 8, m);
    send_bits(8'hF0, 4, 8, m);
    repeat (2) @(negedge clk);
    check("t4_bit_cnt_mid", {29'd0, spi_bit_cnt}, 32'd4);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("t4_rst");
    rst = 1'b0;
    // SSEL still low: the frame must not resume.
    ev0 = ev_total;
    send_bits(8'hFF, 3, 4, m);
    repeat (2) @(negedge clk);
    check("t4_no_resume_bits", {29'd0, spi_bit_cnt}, 32'd0);
    check("t4_no_resume_oe",   {31'd0, MISO_OE},     32'd0);
    check("t4_no_resume_ev",   32'(ev_total - ev0),  32'd0);
    ssel_high();
    ssel_low();
    ev0 = ev_total;
    send_bits(8'h42, 8, 8, m);
    repeat (2) @(negedge clk);
    check("t4_new_ev",   32'(ev_total - ev0), 32'd1);
    check("t4_new_kind", 32'(last_kind),      32'd1);
    check("t4_new_data", {24'd0, last_data},  32'h42);
    check("t4_new_cnt",  last_cnt,            32'd1);
    ssel_high();

    // ---------------- SCK stalls 120 cycles mid-byte ----------------
    ssel_low();
    send_bits(8'h55, 8, 8, m);
    ev0 = ev_total;
    send_bits(8'h96, 4, 8, m);
    repeat (120) @(negedge clk);
`ifdef MCU_SPI_TIMEOUT_EN
    check("t5_abort_oe",       {31'd0, MISO_OE},     32'd0);
    check("t5_abort_bit_cnt",  {29'd0, spi_bit_cnt}, 32'd0);
    check("t5_abort_byte_cnt", spi_byte_cnt,         32'd0);
    send_bits(8'h60, 4, 8, m);
    repeat (2) @(negedge clk);
    check("t5_abort_no_ev",    32'(ev_total - ev0),  32'd0);
`else
    check("t5_stall_oe",       {31'd0, MISO_OE},     32'd1);
    check("t5_stall_bit_cnt",  {29'd0, spi_bit_cnt}, 32'd4);
    send_bits(8'h60, 4, 8, m);   // low nibble of 8'h96
    repeat (2) @(negedge clk);
    check("t5_resume_ev",   32'(ev_total - ev0), 32'd1);
    check("t5_resume_kind", 32'(last_kind),      32'd2);
    check("t5_resume_data", {24'd0, last_data},  32'h96);
    check("t5_resume_cnt",  last_cnt,            32'd2);
`endif
    ssel_high();

    // ---------------- 256 random bytes at SCK = clk/8 ----------------
    ssel_low();
    for (int i = 0; i < 256; i++) begin
      b   = 8'($urandom_range(0, 255));
      ev0 = ev_total;
      send_bits(b, 8, 4, m);
      act = {8'(ev_total - ev0), 8'(last_kind), last_data, last_cnt[7:0]};
      check("t6_rand_byte", act, {8'd1, (i == 0) ? 8'd1 : 8'd2, b, 8'(i + 1)});
    end
    check("t6_final_cnt", spi_byte_cnt, 32'd256);
    ssel_high();
    check("t6_end_byte_cnt", spi_byte_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
